// File: rtl/button_event_fsm.sv
`default_nettype none
// ============================================================================
// Module  : button_event_fsm
// Purpose : Classifies a debounced button into press/release/short/long/repeat events.
// Revision: 1.0 - initial release
// ============================================================================
module button_event_fsm #(
    parameter int LONG_TICKS   = 2000,
    parameter int REPEAT_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic       btn_in,
    input  logic       tick_en,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] event_count
);

    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        LONG     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       count_q, count_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        // Release is tested before any threshold so it always wins a tie.
        case (state_q)
            WAIT_REL: begin
                if (!btn_in) state_d = IDLE;
            end
            IDLE: begin
                if (btn_in) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            PRESSED: begin
                if (!btn_in) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (tick_en) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LONG: begin
                if (!btn_in) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (tick_en) begin
                    if (cnt_q == REPEAT_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = WAIT_REL;
        endcase

        held_d = (state_d == PRESSED) || (state_d == LONG);
    end

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q   <= WAIT_REL;
            cnt_q     <= '0;
            count_q   <= 8'd0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign event_count   = count_q;

endmodule
`default_nettype wire
